// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the memory port A arbiter: default bus widths,
// read-return owner tags and arbitration FSM state encodings.
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    // Owner tag carried from a grant to the following read-return cycle
    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_EXT  = 2'b10;

    typedef enum logic {
        ST_IDLE       = 1'b0,
        ST_EXT_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/arb_read_return.sv
// One-cycle read return path: remembers who owned a read grant and steers
// the RAM's synchronous read data to that requester the following cycle.
// Each requester's rdata holds its last returned word between reads.
module arb_read_return
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_gnt,
    input  logic              ext_gnt,
    input  logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata
);

    logic [1:0]        owner_q;
    logic              rd_q;
    logic [DATA_W-1:0] cpu_hold_q;
    logic [DATA_W-1:0] ext_hold_q;

    // Tag the access issued this cycle so its data can be routed next cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            owner_q <= OWN_NONE;
            rd_q    <= 1'b0;
        end else begin
            owner_q <= cpu_gnt ? OWN_CPU : (ext_gnt ? OWN_EXT : OWN_NONE);
            rd_q    <= (cpu_gnt | ext_gnt) & ~mem_we;
        end
    end

    // A return pending at reset time is dropped rather than delivered
    assign cpu_rvalid = rd_q && (owner_q == OWN_CPU) && !reset;
    assign ext_rvalid = rd_q && (owner_q == OWN_EXT) && !reset;

    // Capture returned words so rdata stays stable until the next return
    always_ff @(posedge clock) begin
        if (reset) begin
            cpu_hold_q <= '0;
            ext_hold_q <= '0;
        end else begin
            if (cpu_rvalid) cpu_hold_q <= mem_rdata;
            if (ext_rvalid) ext_hold_q <= mem_rdata;
        end
    end

    // Present RAM data in the valid cycle itself, the held copy afterwards
    assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_hold_q;
    assign ext_rdata = ext_rvalid ? mem_rdata : ext_hold_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter for memory port A shared by the CPU control path and an external
// requester. CPU has priority; the external side can lock the port for a
// burst. Define ARB_STARVE_GUARD_EN to add a starvation guard that lets a
// refused external request win once it has waited MAX_WAIT cycles.
// Handshake: req is a level held until gnt; gnt means the access reaches
// the RAM in that same cycle, so the requester may move on next cycle.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
`ifdef ARB_STARVE_GUARD_EN
    ,
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = 3
`endif
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic              ext_lock,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output arb_state_t        dbg_state
);

    arb_state_t state;
    arb_state_t state_next;
    logic       locked_hold;
    logic       guard_fire;

`ifdef ARB_STARVE_GUARD_EN
    logic [WAIT_W-1:0] wait_cnt;

    // Count cycles an external request is refused, saturating at MAX_WAIT
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (ext_req && !ext_gnt) begin
            if (wait_cnt != WAIT_W'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    assign guard_fire = (wait_cnt == WAIT_W'(MAX_WAIT));
`else
    assign guard_fire = 1'b0;
`endif

    // The lock only holds while ext_lock stays high; a low sample releases
    // the port in the same cycle so the CPU can win immediately.
    assign locked_hold = (state == ST_EXT_LOCKED) && ext_lock;
    assign dbg_state   = state;

    // Arbitration state register
    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state: enter lock on a locked ext grant, leave when lock drops
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:       if (ext_gnt && ext_lock) state_next = ST_EXT_LOCKED;
            ST_EXT_LOCKED: if (!ext_lock)           state_next = ST_IDLE;
            default:       state_next = ST_IDLE;
        endcase
    end

    // Grant decode: at most one grant, CPU first unless locked or guarded
    always_comb begin
        cpu_gnt = 1'b0;
        ext_gnt = 1'b0;
        if (!reset) begin
            if (locked_hold) begin
                ext_gnt = ext_req;
            end else if (cpu_req && ext_req) begin
                if (guard_fire) ext_gnt = 1'b1;
                else            cpu_gnt = 1'b1;
            end else begin
                cpu_gnt = cpu_req;
                ext_gnt = ext_req;
            end
        end
    end

    // RAM port mux: drive the winner's access, all zero when idle
    always_comb begin
        mem_en    = cpu_gnt | ext_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (ext_gnt) begin
            mem_we    = ext_we;
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
        end
    end

    arb_read_return #(
        .DATA_W (DATA_W)
    ) u_read_return (
        .clock      (clock),
        .reset      (reset),
        .cpu_gnt    (cpu_gnt),
        .ext_gnt    (ext_gnt),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .ext_rvalid (ext_rvalid),
        .ext_rdata  (ext_rdata)
    );

endmodule
